// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the M-stage data-memory access controller:
// load/store size codes, FSM state encoding and size decode helpers.
package dmem_access_ctrl_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Unknown size codes fall back to a full word.
    function automatic size_e store_size(input logic [2:0] sel);
        case (sel)
            LS_B:    return SZ_B;
            LS_H:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic size_e load_size(input logic [2:0] sel);
        case (sel)
            LS_B, LS_BU: return SZ_B;
            LS_H, LS_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication,
// misalignment detection and load lane extraction with extension.
module lsu_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic        is_store_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    input  logic [2:0]  store_sel_i,
    input  logic [2:0]  load_sel_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    output logic [31:0] load_ext_o
);

    size_e       size;
    logic [31:0] rdata_shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign rdata_shifted = rdata_i >> {addr_i[1:0], 3'b000};
    assign byte_v        = rdata_shifted[7:0];
    assign half_v        = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        size         = is_store_i ? store_size(store_sel_i) : load_size(load_sel_i);
        misaligned_o = 1'b0;
        be_o         = 4'b1111;
        wdata_o      = wd_i;
        load_ext_o   = rdata_i;

        case (size)
            SZ_B:    misaligned_o = 1'b0;
            SZ_H:    misaligned_o = addr_i[0];
            default: misaligned_o = |addr_i[1:0];
        endcase

        if (is_store_i) begin
            case (size)
                SZ_B: begin
                    be_o    = 4'b0001 << addr_i[1:0];
                    wdata_o = {4{wd_i[7:0]}};
                end
                SZ_H: begin
                    be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{wd_i[15:0]}};
                end
                default: begin
                    be_o    = 4'b1111;
                    wdata_o = wd_i;
                end
            endcase
        end

        case (load_sel_i)
            LS_B:    load_ext_o = {{24{byte_v[7]}}, byte_v};
            LS_BU:   load_ext_o = {24'h0, byte_v};
            LS_H:    load_ext_o = {{16{half_v[15]}}, half_v};
            LS_HU:   load_ext_o = {16'h0, half_v};
            default: load_ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage data-memory controller: runs one req/ack access per load/store,
// freezes the pipeline while it is outstanding and aborts on bus timeout.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_enable_dmem_M,
    input  logic        mem_read_M,
    input  logic [31:0] alu_rsl_M,
    input  logic [31:0] wd_M,
    input  logic [2:0]  store_sel_M,
    input  logic [2:0]  load_sel_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_M,
    output logic        stall_mem,
    output logic        misaligned_M,
    output logic        bus_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             bus_err_q, bus_err_d;

    logic        acc;
    logic        is_store;
    logic        mis;
    logic        timeout_hit;
    logic [3:0]  be_a;
    logic [31:0] wdata_a;
    logic [31:0] load_ext;

    assign acc      = write_enable_dmem_M | mem_read_M;
    assign is_store = write_enable_dmem_M;

    lsu_align u_align (
        .is_store_i   (is_store),
        .addr_i       (alu_rsl_M),
        .wd_i         (wd_M),
        .store_sel_i  (store_sel_M),
        .load_sel_i   (load_sel_M),
        .rdata_i      (dmem_rdata),
        .be_o         (be_a),
        .wdata_o      (wdata_a),
        .misaligned_o (mis),
        .load_ext_o   (load_ext)
    );

    assign misaligned_M = acc & mis;
    assign dmem_addr    = {alu_rsl_M[31:2], 2'b00};
    assign bus_err      = bus_err_q;

    // Counter holds the number of ack-less BUSY cycles already spent.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        bus_err_d   = 1'b0;
        stall_mem   = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_be     = 4'b0000;
        dmem_wdata  = 32'h0;
        load_data_M = 32'h0;

        case (state_q)
            IDLE: begin
                if (acc && !mis) begin
                    stall_mem = 1'b1;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                stall_mem  = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = is_store;
                dmem_be    = be_a;
                dmem_wdata = is_store ? wdata_a : 32'h0;
                // Ack beats a simultaneous timeout.
                if (dmem_ack) begin
                    data_d  = is_store ? 32'h0 : load_ext;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    data_d    = 32'h0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                load_data_M = data_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so they all update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl (TIMEOUT=4) with a simple ack-driving memory model.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_enable_dmem_M;
    logic        mem_read_M;
    logic [31:0] alu_rsl_M;
    logic [31:0] wd_M;
    logic [2:0]  store_sel_M;
    logic [2:0]  load_sel_M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data_M;
    logic        stall_mem;
    logic        misaligned_M;
    logic        bus_err;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .write_enable_dmem_M (write_enable_dmem_M),
        .mem_read_M          (mem_read_M),
        .alu_rsl_M           (alu_rsl_M),
        .wd_M                (wd_M),
        .store_sel_M         (store_sel_M),
        .load_sel_M          (load_sel_M),
        .dmem_req            (dmem_req),
        .dmem_we             (dmem_we),
        .dmem_addr           (dmem_addr),
        .dmem_be             (dmem_be),
        .dmem_wdata          (dmem_wdata),
        .dmem_ack            (dmem_ack),
        .dmem_rdata          (dmem_rdata),
        .load_data_M         (load_data_M),
        .stall_mem           (stall_mem),
        .misaligned_M        (misaligned_M),
        .bus_err             (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        write_enable_dmem_M = 1'b0;
        mem_read_M          = 1'b0;
        alu_rsl_M           = 32'h0;
        wd_M                = 32'h0;
        store_sel_M         = 3'b000;
        load_sel_M          = 3'b000;
        dmem_ack            = 1'b0;
        dmem_rdata          = 32'h0;
    endtask

    // Runs one access; ack is returned in the BUSY cycle whose index equals
    // ack_wait (negative: never). Reports what the DUT showed.
    task automatic run_access(
        input  logic        we, rd,
        input  logic [31:0] addr, wd,
        input  logic [2:0]  ssel, lsel,
        input  int          ack_wait,
        input  logic [31:0] rdata,
        output int          n_stall, n_req,
        output logic [3:0]  be_seen,
        output logic [31:0] wdata_seen, addr_seen, ld_seen,
        output logic        we_seen, berr_seen, done_ok
    );
        logic prev_req;
        tick();
        write_enable_dmem_M = we;
        mem_read_M          = rd;
        alu_rsl_M           = addr;
        wd_M                = wd;
        store_sel_M         = ssel;
        load_sel_M          = lsel;
        dmem_rdata          = rdata;
        dmem_ack            = 1'b0;
        n_stall = 0; n_req = 0; done_ok = 1'b0; prev_req = 1'b0;
        be_seen = 4'h0; wdata_seen = 32'h0; addr_seen = 32'h0; ld_seen = 32'h0;
        we_seen = 1'b0; berr_seen = 1'b0;
        for (int c = 0; c < 40 && !done_ok; c++) begin
            if (c > 0) tick();
            dmem_ack = dmem_req && (ack_wait >= 0) && (n_req == ack_wait);
            #3;
            if (stall_mem) n_stall++;
            if (dmem_req) begin
                if (n_req == 0) begin
                    be_seen = dmem_be; wdata_seen = dmem_wdata;
                    addr_seen = dmem_addr; we_seen = dmem_we;
                end
                n_req++;
            end else if (prev_req) begin
                ld_seen   = load_data_M;
                berr_seen = bus_err;
                done_ok   = 1'b1;
            end
            prev_req = dmem_req;
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        #3;
        n_vec++; if (dmem_req !== 1'b0) begin n_miss++; $display("FAIL rst_req: got %b want 0", dmem_req); end
        n_vec++; if (stall_mem !== 1'b0) begin n_miss++; $display("FAIL rst_stall: got %b want 0", stall_mem); end
        n_vec++; if (bus_err !== 1'b0) begin n_miss++; $display("FAIL rst_bus_err: got %b want 0", bus_err); end
        n_vec++; if (load_data_M !== 32'h0) begin n_miss++; $display("FAIL rst_load_data: got %h want 0", load_data_M); end
        n_vec++; if ({dmem_we, dmem_be, dmem_wdata} !== 37'h0) begin n_miss++;
            $display("FAIL rst_port_idle: got we=%b be=%b wdata=%h want all 0", dmem_we, dmem_be, dmem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_stores();
        int n_stall, n_req;
        logic [3:0] be;
        logic [31:0] wdata, addr, ld;
        logic we, berr, ok;

        run_access(1'b1, 1'b0, 32'h0000_1003, 32'h0000_00A5, 3'b000, 3'b000, 0, 32'h0,
                   n_stall, n_req, be, wdata, addr, ld, we, berr, ok);
        n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL sb_done: got %b want 1", ok); end
        n_vec++; if (be !== 4'b1000) begin n_miss++; $display("FAIL sb_be: got %b want 1000", be); end
        n_vec++; if (wdata !== 32'hA5A5_A5A5) begin n_miss++; $display("FAIL sb_wdata: got %h want a5a5a5a5", wdata); end
        n_vec++; if (addr !== 32'h0000_1000) begin n_miss++; $display("FAIL sb_addr: got %h want 00001000", addr); end
        n_vec++; if (we !== 1'b1) begin n_miss++; $display("FAIL sb_we: got %b want 1", we); end
        n_vec++; if (n_stall != 2) begin n_miss++; $display("FAIL sb_stall_cycles: got %0d want 2", n_stall); end
        n_vec++; if (n_req != 1) begin n_miss++; $display("FAIL sb_req_cycles: got %0d want 1", n_req); end

        run_access(1'b1, 1'b0, 32'h0000_1002, 32'h1234_BEEF, 3'b001, 3'b000, 1, 32'h0,
                   n_stall, n_req, be, wdata, addr, ld, we, berr, ok);
        n_vec++; if (be !== 4'b1100) begin n_miss++; $display("FAIL sh_be: got %b want 1100", be); end
        n_vec++; if (wdata !== 32'hBEEF_BEEF) begin n_miss++; $display("FAIL sh_wdata: got %h want beefbeef", wdata); end
        n_vec++; if (n_stall != 3) begin n_miss++; $display("FAIL sh_stall_cycles: got %0d want 3", n_stall); end

        // Store and load both high: treated as a store.
        run_access(1'b1, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 3'b010, 3'b010, 0, 32'h0,
                   n_stall, n_req, be, wdata, addr, ld, we, berr, ok);
        n_vec++; if (be !== 4'b1111) begin n_miss++; $display("FAIL sw_be: got %b want 1111", be); end
        n_vec++; if (wdata !== 32'hCAFE_F00D) begin n_miss++; $display("FAIL sw_wdata: got %h want cafef00d", wdata); end
        n_vec++; if (we !== 1'b1) begin n_miss++; $display("FAIL sw_we: got %b want 1", we); end
    endtask

    task automatic test_loads();
        int n_stall, n_req;
        logic [3:0] be;
        logic [31:0] wdata, addr, ld;
        logic we, berr, ok;

        // Ack lands in the same cycle the timeout would fire; ack wins.
        run_access(1'b0, 1'b1, 32'h0000_2002, 32'h0, 3'b000, 3'b001, 3, 32'h8001_1234,
                   n_stall, n_req, be, wdata, addr, ld, we, berr, ok);
        n_vec++; if (ld !== 32'hFFFF_8001) begin n_miss++; $display("FAIL lh_data: got %h want ffff8001", ld); end
        n_vec++; if (n_stall != 5) begin n_miss++; $display("FAIL lh_stall_cycles: got %0d want 5", n_stall); end
        n_vec++; if (be !== 4'b1111) begin n_miss++; $display("FAIL lh_be: got %b want 1111", be); end
        n_vec++; if (we !== 1'b0) begin n_miss++; $display("FAIL lh_we: got %b want 0", we); end
        n_vec++; if (berr !== 1'b0) begin n_miss++; $display("FAIL lh_ack_beats_timeout: got %b want 0", berr); end

        run_access(1'b0, 1'b1, 32'h0000_2002, 32'h0, 3'b000, 3'b101, 0, 32'h8001_1234,
                   n_stall, n_req, be, wdata, addr, ld, we, berr, ok);
        n_vec++; if (ld !== 32'h0000_8001) begin n_miss++; $display("FAIL lhu_data: got %h want 00008001", ld); end

        run_access(1'b0, 1'b1, 32'h0000_2001, 32'h0, 3'b000, 3'b000, 0, 32'h0000_F000,
                   n_stall, n_req, be, wdata, addr, ld, we, berr, ok);
        n_vec++; if (ld !== 32'hFFFF_FFF0) begin n_miss++; $display("FAIL lb_data: got %h want fffffff0", ld); end

        run_access(1'b0, 1'b1, 32'h0000_2003, 32'h0, 3'b000, 3'b100, 0, 32'hF700_0000,
                   n_stall, n_req, be, wdata, addr, ld, we, berr, ok);
        n_vec++; if (ld !== 32'h0000_00F7) begin n_miss++; $display("FAIL lbu_data: got %h want 000000f7", ld); end

        run_access(1'b0, 1'b1, 32'h0000_2004, 32'h0, 3'b000, 3'b010, 2, 32'h1234_5678,
                   n_stall, n_req, be, wdata, addr, ld, we, berr, ok);
        n_vec++; if (ld !== 32'h1234_5678) begin n_miss++; $display("FAIL lw_data: got %h want 12345678", ld); end
        n_vec++; if (wdata !== 32'h0) begin n_miss++; $display("FAIL lw_wdata_zero: got %h want 0", wdata); end
    endtask

    task automatic test_misaligned();
        tick();
        mem_read_M = 1'b1; alu_rsl_M = 32'h0000_3002; load_sel_M = 3'b010;
        for (int c = 0; c < 3; c++) begin
            #3;
            n_vec++; if ({misaligned_M, dmem_req, stall_mem} !== 3'b100) begin n_miss++;
                $display("FAIL lw_misaligned c%0d: got mis=%b req=%b stall=%b want 1 0 0", c, misaligned_M, dmem_req, stall_mem); end
            tick();
        end
        n_vec++; if (load_data_M !== 32'h0) begin n_miss++; $display("FAIL lw_mis_data: got %h want 0", load_data_M); end

        write_enable_dmem_M = 1'b1; mem_read_M = 1'b0; alu_rsl_M = 32'h0000_3001; store_sel_M = 3'b001;
        #3;
        n_vec++; if ({misaligned_M, stall_mem} !== 2'b10) begin n_miss++;
            $display("FAIL sh_misaligned: got mis=%b stall=%b want 1 0", misaligned_M, stall_mem); end

        // Byte at an odd address is aligned; withdraw it before the edge.
        store_sel_M = 3'b000; alu_rsl_M = 32'h0000_3003;
        #1;
        n_vec++; if ({misaligned_M, stall_mem} !== 2'b01) begin n_miss++;
            $display("FAIL sb_odd_aligned: got mis=%b stall=%b want 0 1", misaligned_M, stall_mem); end
        clear_inputs();
        tick();
        #3;
        n_vec++; if (dmem_req !== 1'b0) begin n_miss++; $display("FAIL withdrawn_no_req: got %b want 0", dmem_req); end
    endtask

    task automatic test_timeout();
        int n_stall, n_req;
        logic [3:0] be;
        logic [31:0] wdata, addr, ld;
        logic we, berr, ok;

        run_access(1'b0, 1'b1, 32'h0000_4000, 32'h0, 3'b000, 3'b010, -1, 32'h5555_AAAA,
                   n_stall, n_req, be, wdata, addr, ld, we, berr, ok);
        n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL to_released: got %b want 1", ok); end
        n_vec++; if (n_req != 4) begin n_miss++; $display("FAIL to_busy_cycles: got %0d want 4", n_req); end
        n_vec++; if (berr !== 1'b1) begin n_miss++; $display("FAIL to_bus_err: got %b want 1", berr); end
        n_vec++; if (ld !== 32'h0) begin n_miss++; $display("FAIL to_data: got %h want 0", ld); end
        n_vec++; if (n_stall != 5) begin n_miss++; $display("FAIL to_stall_cycles: got %0d want 5", n_stall); end
        #3;
        n_vec++; if (bus_err !== 1'b0) begin n_miss++; $display("FAIL to_pulse_width: got %b want 0", bus_err); end
    endtask

    task automatic test_reset_mid_access();
        tick();
        mem_read_M = 1'b1; alu_rsl_M = 32'h0000_5000; load_sel_M = 3'b010;
        dmem_rdata = 32'hDEAD_BEEF;
        tick();
        #3;
        n_vec++; if (dmem_req !== 1'b1) begin n_miss++; $display("FAIL mid_busy_req: got %b want 1", dmem_req); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        dmem_rdata = 32'hDEAD_BEEF;
        dmem_ack   = 1'b1;
        #3;
        n_vec++; if ({dmem_req, stall_mem} !== 2'b00) begin n_miss++;
            $display("FAIL mid_rst_idle: got req=%b stall=%b want 0 0", dmem_req, stall_mem); end
        tick();
        dmem_ack = 1'b0;
        #3;
        n_vec++; if (load_data_M !== 32'h0) begin n_miss++; $display("FAIL late_ack_data: got %h want 0", load_data_M); end
        n_vec++; if ({dmem_req, bus_err} !== 2'b00) begin n_miss++;
            $display("FAIL late_ack_quiet: got req=%b bus_err=%b want 0 0", dmem_req, bus_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
